// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP state to the state enum.
package multicycle_pkg;

    localparam int OPC_W = 6;
    localparam int ALU_W = 4;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_ADDR,
        MEM_RD,
        MEM_WR,
        WB_R,
        WB_I,
        WB_MEM,
        BRANCH
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
    localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
    localparam logic [OPC_W-1:0] FN_AND = 6'h24;
    localparam logic [OPC_W-1:0] FN_OR  = 6'h25;
    localparam logic [OPC_W-1:0] FN_NOR = 6'h27;
    localparam logic [OPC_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic             reg_dst;
        logic             mem_read;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_write;
        logic             ir_write;
        logic             pc_write;
        logic             pc_branch;
        logic [ALU_W-1:0] alu_ctrl;
    } ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/status inputs and datapath control outputs of the control unit.
interface multicycle_control_if;
    import multicycle_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic [OPC_W-1:0] funct;
    logic             zero;
    logic             mem_ready;
    logic             RegDst;
    logic             MemRead;
    logic             MemtoReg;
    logic             MemWrite;
    logic             ALUSrc;
    logic             RegWrite;
    logic [ALU_W-1:0] ALUCtrl;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCBranch;
    logic             illegal;
    logic [31:0]      retire_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUCtrl,
               IRWrite, PCWrite, PCBranch, illegal, retire_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUCtrl,
               IRWrite, PCWrite, PCBranch, illegal, retire_count
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational R-type funct decode to ALU control code plus a valid flag.
module alu_ctrl_decode
    import multicycle_pkg::*;
(
    input  logic [OPC_W-1:0] funct,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_NOR:  alu_ctrl = ALU_NOR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with registered, glitch-free datapath controls.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on unknown encodings instead of NOP.
module multicycle_control
    import multicycle_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t           state, state_nxt;
    ctl_t             ctl_q, ctl_nxt;
    logic             primed;
    logic             retire_inc;
    logic [31:0]      retire_q;
    logic [OPC_W-1:0] opcode_q;
    logic [ALU_W-1:0] fn_ctrl;
    logic             fn_valid;
    state_t           bad_state;

    alu_ctrl_decode u_alu_ctrl_decode (
        .funct    (bus.funct),
        .alu_ctrl (fn_ctrl),
        .valid    (fn_valid)
    );

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign bad_state = TRAP;
`else
    assign bad_state = FETCH;
`endif

    always_comb begin
        state_nxt  = state;
        retire_inc = 1'b0;
        case (state)
            FETCH:     state_nxt = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:               state_nxt = fn_valid ? EXEC_R : bad_state;
                    OP_LW, OP_SW, OP_ADDI:  state_nxt = EXEC_ADDR;
                    OP_BEQ:                 state_nxt = BRANCH;
                    default:                state_nxt = bad_state;
                endcase
            end
            EXEC_R:    state_nxt = WB_R;
            EXEC_ADDR: begin
                if (opcode_q == OP_LW)      state_nxt = MEM_RD;
                else if (opcode_q == OP_SW) state_nxt = MEM_WR;
                else                        state_nxt = WB_I;
            end
            MEM_RD:    if (bus.mem_ready) state_nxt = WB_MEM;
            MEM_WR: begin
                if (bus.mem_ready) begin
                    state_nxt  = FETCH;
                    retire_inc = 1'b1;
                end
            end
            WB_R, WB_I, WB_MEM, BRANCH: begin
                state_nxt  = FETCH;
                retire_inc = 1'b1;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            TRAP:      state_nxt = TRAP;
`endif
            default:   state_nxt = FETCH;
        endcase
        // The first cycle out of reset re-enters FETCH so its outputs are issued.
        if (!primed) begin
            state_nxt  = FETCH;
            retire_inc = 1'b0;
        end
    end

    // Controls are computed for the state being entered and registered with it.
    always_comb begin
        ctl_nxt = '0;
        case (state_nxt)
            FETCH: begin
                ctl_nxt.ir_write = 1'b1;
                ctl_nxt.pc_write = 1'b1;
            end
            EXEC_R: begin
                ctl_nxt.reg_dst  = 1'b1;
                ctl_nxt.alu_ctrl = fn_ctrl;
            end
            WB_R: begin
                ctl_nxt.reg_dst   = 1'b1;
                ctl_nxt.alu_ctrl  = ctl_q.alu_ctrl;
                ctl_nxt.reg_write = 1'b1;
            end
            EXEC_ADDR: begin
                ctl_nxt.alu_src  = 1'b1;
                ctl_nxt.alu_ctrl = ALU_ADD;
            end
            WB_I: begin
                ctl_nxt.alu_src   = 1'b1;
                ctl_nxt.alu_ctrl  = ALU_ADD;
                ctl_nxt.reg_write = 1'b1;
            end
            MEM_RD: begin
                ctl_nxt.alu_src  = 1'b1;
                ctl_nxt.alu_ctrl = ALU_ADD;
                ctl_nxt.mem_read = 1'b1;
            end
            WB_MEM: begin
                ctl_nxt.alu_src    = 1'b1;
                ctl_nxt.alu_ctrl   = ALU_ADD;
                ctl_nxt.mem_read   = 1'b1;
                ctl_nxt.mem_to_reg = 1'b1;
                ctl_nxt.reg_write  = 1'b1;
            end
            MEM_WR: begin
                ctl_nxt.alu_src   = 1'b1;
                ctl_nxt.alu_ctrl  = ALU_ADD;
                ctl_nxt.mem_write = 1'b1;
            end
            BRANCH: begin
                ctl_nxt.alu_ctrl  = ALU_SUB;
                ctl_nxt.pc_branch = bus.zero;
            end
            default: ctl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            primed   <= 1'b0;
            ctl_q    <= '0;
            retire_q <= '0;
        end else begin
            state  <= state_nxt;
            primed <= 1'b1;
            ctl_q  <= ctl_nxt;
            if (retire_inc) retire_q <= retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DECODE) opcode_q <= bus.opcode;
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (state_nxt == TRAP) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.RegDst       = ctl_q.reg_dst;
    assign bus.MemRead      = ctl_q.mem_read;
    assign bus.MemtoReg     = ctl_q.mem_to_reg;
    assign bus.MemWrite     = ctl_q.mem_write;
    assign bus.ALUSrc       = ctl_q.alu_src;
    assign bus.RegWrite     = ctl_q.reg_write;
    assign bus.ALUCtrl      = ctl_q.alu_ctrl;
    assign bus.IRWrite      = ctl_q.ir_write;
    assign bus.PCWrite      = ctl_q.pc_write;
    assign bus.PCBranch     = ctl_q.pc_branch;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; control vector order is
// {RegDst,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,IRWrite,PCWrite,PCBranch,ALUCtrl[3:0]}.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if bus_i ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_retire = 32'd0;

    logic [12:0] ctl_obs;
    assign ctl_obs = {bus_i.RegDst, bus_i.MemRead, bus_i.MemtoReg, bus_i.MemWrite,
                      bus_i.ALUSrc, bus_i.RegWrite, bus_i.IRWrite, bus_i.PCWrite,
                      bus_i.PCBranch, bus_i.ALUCtrl};

    localparam logic [12:0] C_F    = 13'h060;
    localparam logic [12:0] C_ADDR = 13'h102;
    localparam logic [12:0] C_WBI  = 13'h182;
    localparam logic [12:0] C_MRD  = 13'h902;
    localparam logic [12:0] C_WBM  = 13'hD82;
    localparam logic [12:0] C_MWR  = 13'h302;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_i.opcode = 6'h00;
        bus_i.funct = 6'h20;
        bus_i.zero = 1'b0;
        bus_i.mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (ctl_obs !== 13'h0) begin
            errors++;
            $display("FAIL reset_ctl got %h expected %h", ctl_obs, 13'h0);
        end
        checks++;
        if (bus_i.retire_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_retire got %h expected %h", bus_i.retire_count, 32'd0);
        end
        checks++;
        if (bus_i.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal got %b expected 0", bus_i.illegal);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ctl_obs !== C_F) begin
            errors++;
            $display("FAIL reset_release_fetch got %h expected %h", ctl_obs, C_F);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [6];
        logic [3:0]  ac [6];
        logic [12:0] exp [4];
        fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        ac = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        for (int i = 0; i < 6; i++) begin
            bus_i.opcode = 6'h00;
            bus_i.funct = fn[i];
            exp = '{13'h0, {9'h100, ac[i]}, {9'h108, ac[i]}, C_F};
            for (int j = 0; j < 4; j++) begin
                tick();
                checks++;
                if (ctl_obs !== exp[j]) begin
                    errors++;
                    $display("FAIL rtype_f%h_cyc%0d got %h expected %h", fn[i], j + 2, ctl_obs, exp[j]);
                end
            end
            exp_retire++;
            checks++;
            if (bus_i.retire_count !== exp_retire) begin
                errors++;
                $display("FAIL rtype_retire got %h expected %h", bus_i.retire_count, exp_retire);
            end
        end
    endtask

    task automatic test_addi();
        logic [12:0] exp [4];
        exp = '{13'h0, C_ADDR, C_WBI, C_F};
        bus_i.opcode = 6'h08;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (ctl_obs !== exp[j]) begin
                errors++;
                $display("FAIL addi_cyc%0d got %h expected %h", j + 2, ctl_obs, exp[j]);
            end
        end
        exp_retire++;
        checks++;
        if (bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL addi_retire got %h expected %h", bus_i.retire_count, exp_retire);
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy [8];
        logic [12:0] exp [8];
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{13'h0, C_ADDR, C_MRD, C_MRD, C_MRD, C_MRD, C_WBM, C_F};
        bus_i.opcode = 6'h23;
        for (int j = 0; j < 8; j++) begin
            bus_i.mem_ready = rdy[j];
            tick();
            checks++;
            if (ctl_obs !== exp[j]) begin
                errors++;
                $display("FAIL lw_wait_cyc%0d got %h expected %h", j + 2, ctl_obs, exp[j]);
            end
        end
        bus_i.mem_ready = 1'b1;
        exp_retire++;
        checks++;
        if (bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL lw_retire got %h expected %h", bus_i.retire_count, exp_retire);
        end
    endtask

    task automatic test_sw();
        logic [12:0] exp [4];
        exp = '{13'h0, C_ADDR, C_MWR, C_F};
        bus_i.opcode = 6'h2B;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (ctl_obs !== exp[j]) begin
                errors++;
                $display("FAIL sw_cyc%0d got %h expected %h", j + 2, ctl_obs, exp[j]);
            end
        end
        exp_retire++;
        checks++;
        if (bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL sw_retire got %h expected %h", bus_i.retire_count, exp_retire);
        end
    endtask

    task automatic test_beq();
        logic [12:0] exp [3];
        for (int z = 1; z >= 0; z--) begin
            bus_i.opcode = 6'h04;
            bus_i.zero = (z == 1);
            exp = '{13'h0, (z == 1) ? 13'h016 : 13'h006, C_F};
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++;
                if (ctl_obs !== exp[j]) begin
                    errors++;
                    $display("FAIL beq_z%0d_cyc%0d got %h expected %h", z, j + 2, ctl_obs, exp[j]);
                end
            end
            exp_retire++;
            checks++;
            if (bus_i.retire_count !== exp_retire) begin
                errors++;
                $display("FAIL beq_retire got %h expected %h", bus_i.retire_count, exp_retire);
            end
        end
        bus_i.zero = 1'b0;
    endtask

    task automatic test_reset_mem_wr();
        logic [12:0] exp [4];
        exp = '{13'h0, C_ADDR, C_MWR, C_MWR};
        bus_i.opcode = 6'h2B;
        bus_i.mem_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (ctl_obs !== exp[j]) begin
                errors++;
                $display("FAIL rstwr_cyc%0d got %h expected %h", j + 2, ctl_obs, exp[j]);
            end
        end
        rst_n = 1'b0;
        tick();
        exp_retire = 32'd0;
        checks++;
        if (ctl_obs !== 13'h0) begin
            errors++;
            $display("FAIL rstwr_ctl got %h expected %h", ctl_obs, 13'h0);
        end
        rst_n = 1'b1;
        bus_i.mem_ready = 1'b1;
        tick();
        checks++;
        if (ctl_obs !== C_F) begin
            errors++;
            $display("FAIL rstwr_fetch got %h expected %h", ctl_obs, C_F);
        end
        checks++;
        if (bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL rstwr_retire got %h expected %h", bus_i.retire_count, exp_retire);
        end
    endtask

    task automatic test_illegal();
        bus_i.opcode = 6'h3F;
        tick();
        checks++;
        if (ctl_obs !== 13'h0) begin
            errors++;
            $display("FAIL illegal_decode got %h expected %h", ctl_obs, 13'h0);
        end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        bus_i.opcode = 6'h00;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (ctl_obs !== 13'h0 || bus_i.illegal !== 1'b1) begin
                errors++;
                $display("FAIL trap_hold_%0d got ctl=%h illegal=%b expected ctl=0000 illegal=1", j, ctl_obs, bus_i.illegal);
            end
        end
        rst_n = 1'b0;
        tick();
        exp_retire = 32'd0;
        checks++;
        if (bus_i.illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset_illegal got %b expected 0", bus_i.illegal);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ctl_obs !== C_F) begin
            errors++;
            $display("FAIL trap_recover_fetch got %h expected %h", ctl_obs, C_F);
        end
`else
        tick();
        checks++;
        if (ctl_obs !== C_F) begin
            errors++;
            $display("FAIL nop_fetch got %h expected %h", ctl_obs, C_F);
        end
        checks++;
        if (bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL nop_retire got %h expected %h", bus_i.retire_count, exp_retire);
        end
        checks++;
        if (bus_i.illegal !== 1'b0) begin
            errors++;
            $display("FAIL nop_illegal got %b expected 0", bus_i.illegal);
        end
        bus_i.opcode = 6'h00;
        bus_i.funct = 6'h00;
        tick();
        tick();
        checks++;
        if (ctl_obs !== C_F || bus_i.retire_count !== exp_retire) begin
            errors++;
            $display("FAIL nop_funct got ctl=%h retire=%h expected ctl=%h retire=%h", ctl_obs, bus_i.retire_count, C_F, exp_retire);
        end
        bus_i.funct = 6'h20;
`endif
    endtask

    task automatic test_wrap();
        logic [12:0] exp [4];
        exp = '{13'h0, C_ADDR, C_MWR, C_F};
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        bus_i.opcode = 6'h2B;
        bus_i.mem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (ctl_obs !== exp[j]) begin
                errors++;
                $display("FAIL wrap_cyc%0d got %h expected %h", j + 2, ctl_obs, exp[j]);
            end
            if (j == 0) begin
                checks++;
                if (bus_i.retire_count !== 32'hFFFF_FFFF) begin
                    errors++;
                    $display("FAIL wrap_preload got %h expected %h", bus_i.retire_count, 32'hFFFF_FFFF);
                end
            end
        end
        checks++;
        if (bus_i.retire_count !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_retire got %h expected %h", bus_i.retire_count, 32'h0);
        end
    endtask

    initial begin
        bus_i.opcode = 6'h00;
        bus_i.funct = 6'h20;
        bus_i.zero = 1'b0;
        bus_i.mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_sw();
        test_beq();
        test_reset_mem_wr();
        test_illegal();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
